pe_drain: RTL and testbench

Run controller and result drain for one row of `COLS` systolic `pe` cells.
- Drives the shared `pe_en` for a fixed accumulation window.
- Snapshots the row's 36-bit accumulators in the one cycle before the deasserted enable clears them.
- Streams the results out one column at a time over a valid/ready interface, rounded and saturated back to unsigned fix_8_8.
- Sits at the bottom of a PE row and reads what the cells write into `sum`.

---
 rtl/attn_pkg.sv | 16 +
 rtl/pe_drain_if.sv | 24 ++
 rtl/sum_to_fix88.sv | 21 ++
 rtl/pe_drain.sv | 108 ++++++++++
 tb/tb_pe_drain.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/attn_pkg.sv
// Shared widths and run-state encoding for the attention PE row logic.
// Accumulators are unsigned fix_20_16; drained results are unsigned fix_8_8.
package attn_pkg;

    localparam int SUM_W  = 36;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

endpackage

// File: rtl/pe_drain_if.sv
// Result stream from the row drain: valid/ready with a last-column marker.
// The master drives data, valid and last; the slave answers with ready.
interface pe_drain_if;

    logic [attn_pkg::DATA_W-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/sum_to_fix88.sv
// Combinational fix_20_16 -> fix_8_8 converter: round half up, saturate.
// Also used by the column drain of the full array.
module sum_to_fix88
    import attn_pkg::*;
(
    input  logic [SUM_W-1:0]  sum_i,
    output logic [DATA_W-1:0] fix_o
);

    logic [DATA_W:0] rnd;
    logic            ovf;

    always_comb begin
        rnd = {1'b0, sum_i[FRAC_W+DATA_W-1:FRAC_W]}
            + {{DATA_W{1'b0}}, sum_i[FRAC_W-1]};
        // Integer bits beyond 8, or a carry out of the rounding add
        ovf = (|sum_i[SUM_W-1:FRAC_W+DATA_W]) | rnd[DATA_W];
        fix_o = ovf ? {DATA_W{1'b1}} : rnd[DATA_W-1:0];
    end

endmodule

// File: rtl/pe_drain.sv
// Run controller for one systolic PE row: drives pe_en for a fixed window,
// snapshots the accumulators, then streams them out one column at a time.
module pe_drain
    import attn_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int ACC_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [COLS*SUM_W-1:0] sum_flat,
    output logic                  pe_en,
    output logic                  busy,
    pe_drain_if.master            out
);

    localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COLS - 1);

    state_e           state_q, state_d;
    logic             pe_en_q, pe_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUM_W-1:0] shadow_q [COLS];
    logic             capture;
    logic             hs;
    logic [DATA_W-1:0] conv;

    assign hs = out.out_valid && out.out_ready;

    always_comb begin
        state_d = state_q;
        pe_en_d = pe_en_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pe_en_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    pe_en_d = 1'b0;
                    state_d = CAPTURE;
                end
            end
            // PEs still hold their final sums; they clear on this same edge
            CAPTURE: begin
                capture = 1'b1;
                idx_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (hs) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pe_en_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            for (int c = 0; c < COLS; c++) begin
                shadow_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            pe_en_q <= pe_en_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (capture) begin
                for (int c = 0; c < COLS; c++) begin
                    shadow_q[c] <= sum_flat[c*SUM_W +: SUM_W];
                end
            end
        end
    end

    sum_to_fix88 u_conv (
        .sum_i (shadow_q[idx_q]),
        .fix_o (conv)
    );

    assign pe_en         = pe_en_q;
    assign busy          = (state_q != IDLE);
    assign out.out_valid = (state_q == DRAIN);
    assign out.out_last  = (state_q == DRAIN) && (idx_q == IDX_LAST);
    assign out.out_data  = (state_q == DRAIN) ? conv : '0;

endmodule

// File: tb/tb_pe_drain.sv
// Directed bench for pe_drain: enable window, conversion, backpressure,
// ignored start, back-to-back runs and asynchronous reset.
module tb_pe_drain;

    localparam int COLS = 4;
    localparam int ACC  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [COLS*36-1:0] sum_flat;
    logic             pe_en;
    logic             busy;

    pe_drain_if u_if ();

    pe_drain #(.COLS(COLS), .ACC_CYCLES(ACC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sum_flat (sum_flat),
        .pe_en    (pe_en),
        .busy     (busy),
        .out      (u_if.master)
    );

    always #5 clk = ~clk;

    // PE row model and direct sum source
    logic        use_pe = 1'b0;
    logic [15:0] a_v [COLS];
    logic [15:0] b_v [COLS];
    logic [35:0] pe_acc [COLS];
    logic [35:0] direct [COLS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) pe_acc[c] <= '0;
        end else begin
            for (int c = 0; c < COLS; c++)
                pe_acc[c] <= pe_en ? pe_acc[c] + ({20'b0, a_v[c]} * {20'b0, b_v[c]}) : 36'd0;
        end
    end

    always_comb begin
        sum_flat = '0;
        for (int c = 0; c < COLS; c++)
            sum_flat[c*36 +: 36] = use_pe ? pe_acc[c] : direct[c];
    end

    // Edge monitor: values read here are the pre-edge ones
    int cyc = 0, en_edges = 0, first_en_edge = 0, last_en_edge = 0;
    int t_start = 0, n_starts = 0, first_valid_edge = 0, hs_cnt = 0, last_hs_edge = 0;
    logic prev_en = 1'b0, prev_valid = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pe_en) begin
            en_edges <= en_edges + 1;
            last_en_edge <= cyc;
            if (!prev_en) first_en_edge <= cyc;
        end
        prev_en <= pe_en;
        if (rst_n && start && !busy) begin
            t_start <= cyc;
            n_starts <= n_starts + 1;
        end
        if (u_if.out_valid && !prev_valid) first_valid_edge <= cyc;
        prev_valid <= u_if.out_valid;
        if (u_if.out_valid && u_if.out_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (u_if.out_last) last_hs_edge <= cyc;
        end
    end

    int passed = 0, total = 0;
    logic [15:0] got_d [COLS];
    logic        got_l [COLS];
    int got_n = 0, bad_hold = 0;
    logic [15:0] exp_d [COLS];

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain_collect(input int stall_col, input int stall_len);
        int n, st;
        logic [15:0] hd;
        logic hl;
        n = 0; st = 0; hd = '0; hl = 1'b0; bad_hold = 0;
        for (int k = 0; k < 80 && n < COLS; k++) begin
            @(negedge clk);
            if (!u_if.out_valid) begin
                if (n > 0) bad_hold++;
                u_if.out_ready = 1'b0;
            end else if (n == stall_col && st < stall_len) begin
                if (st == 0) begin
                    hd = u_if.out_data;
                    hl = u_if.out_last;
                end else if (u_if.out_data !== hd || u_if.out_last !== hl) begin
                    bad_hold++;
                end
                st++;
                u_if.out_ready = 1'b0;
            end else begin
                if (n == stall_col && st > 0 && (u_if.out_data !== hd || u_if.out_last !== hl))
                    bad_hold++;
                u_if.out_ready = 1'b1;
                got_d[n] = u_if.out_data;
                got_l[n] = u_if.out_last;
                n++;
            end
        end
        got_n = n;
        @(posedge clk);
        #1 u_if.out_ready = 1'b0;
    endtask

    task automatic check_drain(input string tag);
        total++;
        if (got_n !== COLS) $display("FAIL %s handshakes: got %0d want %0d", tag, got_n, COLS);
        else passed++;
        for (int c = 0; c < COLS; c++) begin
            total++;
            if (got_d[c] !== exp_d[c] || got_l[c] !== (c == COLS - 1))
                $display("FAIL %s col%0d: got %h/%b want %h/%b", tag, c, got_d[c], got_l[c],
                         exp_d[c], (c == COLS - 1));
            else passed++;
        end
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (u_if.out_valid) ok = 1'b1;
        end
        total++;
        if (!ok) $display("FAIL %s wait_valid: got timeout want out_valid", tag);
        else passed++;
    endtask

    task automatic test_reset();
        u_if.out_ready = 1'b0;
        use_pe = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            direct[c] = 36'h0_0000_0100 * (c + 5);
            a_v[c] = '0;
            b_v[c] = '0;
        end
        repeat (3) @(negedge clk);
        total++;
        if ({pe_en, busy, u_if.out_valid, u_if.out_last, u_if.out_data} !== 20'h0)
            $display("FAIL reset_in: got %b%b%b%b %h want all 0", pe_en, busy,
                     u_if.out_valid, u_if.out_last, u_if.out_data);
        else passed++;
        rst_n = 1'b1;
        // Reset while RUN: pe_en must drop without a clock edge
        start_run();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (pe_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_run: got pe_en=%b busy=%b want 0 0", pe_en, busy);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        // Reset mid-DRAIN with the consumer stalled
        start_run();
        wait_valid("reset_drain");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({pe_en, busy, u_if.out_valid, u_if.out_last, u_if.out_data} !== 20'h0)
            $display("FAIL reset_drain: got %b%b%b%b %h want all 0", pe_en, busy,
                     u_if.out_valid, u_if.out_last, u_if.out_data);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        start_run();
        drain_collect(-1, 0);
        exp_d[0] = 16'h0005; exp_d[1] = 16'h0006; exp_d[2] = 16'h0007; exp_d[3] = 16'h0008;
        check_drain("after_reset");
    endtask

    task automatic test_enable_window();
        int en0;
        use_pe = 1'b1;
        a_v[0] = 16'h0100; b_v[0] = 16'h0100;
        a_v[1] = 16'h0180; b_v[1] = 16'h0200;
        a_v[2] = 16'h0011; b_v[2] = 16'h0003;
        a_v[3] = 16'hFFFF; b_v[3] = 16'hFFFF;
        @(negedge clk);
        en0 = en_edges;
        start_run();
        drain_collect(-1, 0);
        total++;
        if (en_edges - en0 !== ACC)
            $display("FAIL en_count: got %0d want %0d", en_edges - en0, ACC);
        else passed++;
        total++;
        if (first_en_edge !== t_start + 1 || last_en_edge !== t_start + ACC)
            $display("FAIL en_window: got %0d..%0d want %0d..%0d", first_en_edge - t_start,
                     last_en_edge - t_start, 1, ACC);
        else passed++;
        total++;
        if (first_valid_edge !== t_start + ACC + 2)
            $display("FAIL first_valid: got T+%0d want T+%0d", first_valid_edge - t_start, ACC + 2);
        else passed++;
        exp_d[0] = 16'h0800; exp_d[1] = 16'h1800; exp_d[2] = 16'h0002; exp_d[3] = 16'hFFFF;
        check_drain("pe_sums");
    endtask

    task automatic test_conversion();
        use_pe = 1'b0;
        direct[0] = 36'h0_0001_8000;
        direct[1] = 36'h0_0000_0080;
        direct[2] = 36'h0_0000_007F;
        direct[3] = 36'h1_0000_0000;
        start_run();
        drain_collect(-1, 0);
        exp_d[0] = 16'h0180; exp_d[1] = 16'h0001; exp_d[2] = 16'h0000; exp_d[3] = 16'hFFFF;
        check_drain("conv");
    endtask

    task automatic test_backpressure();
        int hs0;
        use_pe = 1'b0;
        direct[0] = 36'h0_0000_0100;
        direct[1] = 36'h0_0000_0200;
        direct[2] = 36'h0_0000_0300;
        direct[3] = 36'h0_0000_0400;
        @(negedge clk);
        hs0 = hs_cnt;
        start_run();
        drain_collect(1, 3);
        total++;
        if (bad_hold !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad_hold);
        else passed++;
        total++;
        if (hs_cnt - hs0 !== COLS) $display("FAIL bp_hs: got %0d want %0d", hs_cnt - hs0, COLS);
        else passed++;
        exp_d[0] = 16'h0001; exp_d[1] = 16'h0002; exp_d[2] = 16'h0003; exp_d[3] = 16'h0004;
        check_drain("bp");
    endtask

    task automatic test_ignored_start();
        int en0, st0;
        use_pe = 1'b1;
        @(negedge clk);
        en0 = en_edges;
        st0 = n_starts;
        start_run();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("ign_drain");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain_collect(-1, 0);
        repeat (12) @(negedge clk);
        total++;
        if (en_edges - en0 !== ACC || n_starts - st0 !== 1)
            $display("FAIL ign_start: got en=%0d runs=%0d want en=%0d runs=1",
                     en_edges - en0, n_starts - st0, ACC);
        else passed++;
        total++;
        if (pe_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL ign_idle: got pe_en=%b busy=%b want 0 0", pe_en, busy);
        else passed++;
        exp_d[0] = 16'h0800; exp_d[1] = 16'h1800; exp_d[2] = 16'h0002; exp_d[3] = 16'hFFFF;
        check_drain("ign");
    endtask

    task automatic test_back_to_back();
        use_pe = 1'b0;
        direct[0] = 36'h0_0000_0100;
        direct[1] = 36'h0_0000_0100;
        direct[2] = 36'h0_0000_0100;
        direct[3] = 36'h0_0000_0100;
        start_run();
        drain_collect(-1, 0);
        @(negedge clk);
        start = 1'b1;
        direct[0] = 36'h0_00FF_FF80;
        direct[1] = 36'h0_0000_0180;
        direct[2] = 36'h0_0012_3400;
        direct[3] = 36'h0_00FF_FF7F;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b want 0", busy);
        else passed++;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || t_start !== last_hs_edge + 1)
            $display("FAIL b2b_accept: got busy=%b start@+%0d want 1 @+1", busy,
                     t_start - last_hs_edge);
        else passed++;
        drain_collect(-1, 0);
        total++;
        if (first_en_edge !== t_start + 1)
            $display("FAIL b2b_en: got T+%0d want T+1", first_en_edge - t_start);
        else passed++;
        exp_d[0] = 16'hFFFF; exp_d[1] = 16'h0002; exp_d[2] = 16'h1234; exp_d[3] = 16'hFFFF;
        check_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_enable_window();
        test_conversion();
        test_backpressure();
        test_ignored_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
